pcs_lane_distributor_am: RTL



---
 rtl/pcs_tx_pkg.sv | 37 +++
 rtl/pcs_bip_lane_acc.sv | 38 +++
 rtl/pcs_lane_distributor_am.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pcs_tx_pkg.sv
// Shared definitions for the TX lane distributor: AM sync header, marker field
// offsets, row state encoding and the BIP3 parity mapping.
package pcs_tx_pkg;

  localparam logic [1:0] AM_SYNC = 2'b10;

  // Offsets of {M0,M1,M2} inside one lane's 24-bit marker word
  localparam int M0_OFS = 16;
  localparam int M1_OFS = 8;
  localparam int M2_OFS = 0;

  typedef enum logic {
    DATA_ROW = 1'b0,
    AM_ROW   = 1'b1
  } row_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bit i collects block bits k in 2..65 with k mod 8 == (i+2) mod 8;
  // the two sync-header bits 0/1 additionally fold into bits 3/4.
  function automatic logic [7:0] bip_calc(input logic [65:0] blk);
    logic [63:0] body;
    logic [7:0]  bip;
    body = blk[65:2];
    bip  = '0;
    for (int j = 0; j < 8; j++) bip ^= body[8*j +: 8];
    bip[3] ^= blk[0];
    bip[4] ^= blk[1];
    return bip;
  endfunction

endpackage

// File: rtl/pcs_bip_lane_acc.sv
// Per-lane BIP accumulator; also builds the lane's alignment-marker block from
// the markers and the accumulator value held before the current row.
module pcs_bip_lane_acc
  import pcs_tx_pkg::*;
#(
  parameter int NB_DATA_CODED = 66,
  parameter int NB_BIP        = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     data_en,
  input  logic                     am_en,
  input  logic [NB_DATA_CODED-1:0] block,
  input  logic [23:0]              markers,
  output logic [NB_DATA_CODED-1:0] am_block
);

  logic [NB_BIP-1:0] acc;
  logic [7:0]        m0, m1, m2;

  assign m0 = markers[M0_OFS +: 8];
  assign m1 = markers[M1_OFS +: 8];
  assign m2 = markers[M2_OFS +: 8];

  assign am_block = {AM_SYNC, m0, m1, m2, acc, ~m0, ~m1, ~m2, ~acc};

  // An inserted AM restarts the parity run from the AM block itself
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc <= '0;
    end else if (am_en) begin
      acc <= bip_calc(am_block);
    end else if (data_en) begin
      acc <= acc ^ bip_calc(block);
    end
  end

endmodule

// File: rtl/pcs_lane_distributor_am.sv
// Round-robin distribution of 66b blocks over the active PCS lanes, with
// per-lane alignment-marker substitution and AM period policing.
//
// state    | meaning
// DATA_ROW | current row carries data blocks
// AM_ROW   | lane 0 was tagged; every slot of this row becomes that lane's AM
module pcs_lane_distributor_am
  import pcs_tx_pkg::*;
#(
  parameter int NB_DATA_CODED   = 66,
  parameter int N_LANES         = 20,
  parameter int NB_BIP          = 8,
  parameter int AM_BLOCK_PERIOD = 16383,
  parameter int NB_LANE_SEL     = 5
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_enable,
  input  logic                             i_valid,
  input  logic [NB_DATA_CODED-1:0]         i_data,
  input  logic                             i_aligner_tag,
  input  logic [NB_LANE_SEL-1:0]           i_active_lanes,
  input  logic [24*N_LANES-1:0]            i_am_markers,
  output logic [NB_DATA_CODED*N_LANES-1:0] o_data,
  output logic                             o_valid,
  output logic                             o_am_row,
  output logic                             o_align_err
);

  localparam int NB_ROW_CNT = clog2(AM_BLOCK_PERIOD + 2);
  localparam logic [NB_ROW_CNT-1:0]  PERIOD     = NB_ROW_CNT'(AM_BLOCK_PERIOD);
  localparam logic [NB_ROW_CNT-1:0]  PERIOD_SAT = NB_ROW_CNT'(AM_BLOCK_PERIOD + 1);
  localparam logic [NB_LANE_SEL-1:0] LANES_MAX  = NB_LANE_SEL'(N_LANES);

  row_state_t                       state;
  logic [NB_LANE_SEL-1:0]           lane_idx, active_q, active_cfg, active_cnt;
  logic [NB_ROW_CNT-1:0]            row_cnt;
  logic                             cfg_locked, first_am_seen;
  logic                             accept, last_lane, am_now, tag_err, period_err;
  logic [NB_DATA_CODED*N_LANES-1:0] row_next;

  assign active_cfg = (i_active_lanes == '0 || i_active_lanes > LANES_MAX) ?
                      LANES_MAX : i_active_lanes;
  // The first cycle after reset release uses the live pin value directly
  assign active_cnt = cfg_locked ? active_q : active_cfg;
  assign accept     = i_enable & i_valid;
  assign last_lane  = (lane_idx == active_cnt - NB_LANE_SEL'(1));
  assign am_now     = (lane_idx == '0) ? i_aligner_tag : (state == AM_ROW);
  assign tag_err    = accept && (lane_idx != '0) && (i_aligner_tag != (state == AM_ROW));
  assign period_err = accept && last_lane &&
                      (am_now ? (first_am_seen && row_cnt != PERIOD) : (row_cnt == PERIOD));

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic                     hit;
    logic [NB_DATA_CODED-1:0] am_blk, slot, shadow;

    assign hit  = accept && (lane_idx == NB_LANE_SEL'(k));
    assign slot = am_now ? am_blk : i_data;

    pcs_bip_lane_acc #(
      .NB_DATA_CODED (NB_DATA_CODED),
      .NB_BIP        (NB_BIP)
    ) u_acc (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .data_en  (hit && !am_now),
      .am_en    (hit && am_now),
      .block    (i_data),
      .markers  (i_am_markers[24*k +: 24]),
      .am_block (am_blk)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)  shadow <= '0;
      else if (hit)  shadow <= slot;
    end

    assign row_next[NB_DATA_CODED*k +: NB_DATA_CODED] =
      (NB_LANE_SEL'(k) >= active_cnt) ? '0 : (hit ? slot : shadow);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= DATA_ROW;
      lane_idx      <= '0;
      row_cnt       <= '0;
      first_am_seen <= 1'b0;
      active_q      <= LANES_MAX;
      cfg_locked    <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_am_row      <= 1'b0;
      o_align_err   <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_align_err <= tag_err | period_err;
      cfg_locked  <= 1'b1;
      if (!i_enable || !cfg_locked) active_q <= active_cfg;

      if (!i_enable) begin
        lane_idx <= '0;
        state    <= DATA_ROW;
      end else if (i_valid) begin
        if (last_lane) begin
          lane_idx <= '0;
          state    <= DATA_ROW;
          o_data   <= row_next;
          o_valid  <= 1'b1;
          o_am_row <= am_now;
          if (am_now) begin
            row_cnt       <= '0;
            first_am_seen <= 1'b1;
          end else if (row_cnt != PERIOD_SAT) begin
            row_cnt <= row_cnt + 1'b1;
          end
        end else begin
          lane_idx <= lane_idx + 1'b1;
          state    <= am_now ? AM_ROW : DATA_ROW;
        end
      end
    end
  end

endmodule
